postproc_denorm: RTL

- Inverse of the front-end normaliser: takes a left-justified sample plus the shift amount that produced it and restores the original magnitude by a right shift, with optional round-to-nearest.
- Sits at the back end of the processing chain, consuming normalised data and shift tags carried alongside the datapath.
- Multi-cycle FSM with valid/ready handshakes on both sides and a running output-sample counter.

---
 rtl/postproc_denorm.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/postproc_denorm.sv
// rtl/postproc_denorm.sv - back-end denormaliser: right-shift restore with optional rounding
//
// Purpose:
//   Takes a left-justified sample and the shift tag the front-end normaliser
//   applied to it. The original magnitude is restored by a right shift, with
//   optional round-half-up on the last bit shifted out. Each sample walks
//   IDLE -> SHIFT -> ROUND -> SEND, so the block takes at least four cycles
//   per sample.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     upstream sample/shift valid
//   in_ready     block can accept (IDLE only)
//   data_in      normalised sample, NORM_WIDTH bits
//   shift_in     shift applied by the normaliser, SHIFT_WIDTH bits
//   out_valid    data_out valid
//   out_ready    downstream accepts
//   data_out     restored sample, DATA_WIDTH bits
//   shift_err    sticky flag: an out-of-range shift tag was accepted
//   sample_count completed output handshakes, wraps
module postproc_denorm #(
  parameter int DATA_WIDTH  = 16,
  parameter int NORM_WIDTH  = DATA_WIDTH,
  parameter int SHIFT_WIDTH = $clog2(NORM_WIDTH),
  parameter int ROUND_EN    = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NORM_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   shift_err,
  output logic [COUNT_WIDTH-1:0] sample_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    SEND  = 2'd3
  } state_t;

  // Largest legal shift tag, one bit wider than the tag so the compare
  // cannot wrap when 2^SHIFT_WIDTH == NORM_WIDTH.
  localparam logic [SHIFT_WIDTH:0] MAX_SHIFT = (SHIFT_WIDTH+1)'(NORM_WIDTH - 1);
  localparam logic                 ROUND_ON  = (ROUND_EN != 0);

  state_t                 state_q, state_d;
  logic [NORM_WIDTH-1:0]  data_q, data_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [NORM_WIDTH-1:0]  shifted_q, shifted_d;
  logic                   round_q, round_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   shift_err_q, shift_err_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [NORM_WIDTH-1:0]  pre_shift;
  logic [NORM_WIDTH:0]    sum;

  assign in_ready     = (state_q == IDLE) && reset;
  assign out_valid    = out_valid_q;
  assign data_out     = data_out_q;
  assign shift_err    = shift_err_q;
  assign sample_count = count_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    shift_d     = shift_q;
    shifted_d   = shifted_q;
    round_d     = round_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    shift_err_d = shift_err_q;
    count_d     = count_q;
    pre_shift   = '0;
    sum         = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = data_in;
          shift_d = shift_in;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if ({1'b0, shift_q} > MAX_SHIFT) begin
          shifted_d   = '0;
          round_d     = 1'b0;
          shift_err_d = 1'b1;
        end else if (shift_q == '0) begin
          shifted_d = data_q;
          round_d   = 1'b0;
        end else begin
          // Shift by (shift-1) first: bit 0 is then the last bit that the
          // full shift discards, i.e. the rounding bit.
          pre_shift = data_q >> (shift_q - SHIFT_WIDTH'(1));
          shifted_d = pre_shift >> 1;
          round_d   = pre_shift[0];
        end
        state_d = SHIFT == SHIFT ? ROUND : ROUND;
      end

      ROUND: begin
        sum = {1'b0, shifted_q} + (NORM_WIDTH+1)'(round_q & ROUND_ON);
        // Any set bit above the output width means the value does not fit.
        if (|sum[NORM_WIDTH:DATA_WIDTH]) begin
          data_out_d = '1;
        end else begin
          data_out_d = sum[DATA_WIDTH-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = SEND;
      end

      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          count_d     = count_q + COUNT_WIDTH'(1);
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      shift_q     <= '0;
      shifted_q   <= '0;
      round_q     <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      shift_err_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      shifted_q   <= shifted_d;
      round_q     <= round_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      shift_err_q <= shift_err_d;
      count_q     <= count_d;
    end
  end

endmodule
